// File: rtl/lut_page_loader.sv
// Write-side loader for the two-bank interleaved IB-LUT page memory.
// Packs a word stream into pages and issues one-cycle page writes.
module lut_page_loader #(
  parameter int QUAN_SIZE       = 3,
  parameter int PAGE_NUM        = 16,
  parameter int BANK_INTERLEAVE = 2,
  parameter int ADDR_BITWIDTH   = 4
) (
  input  logic                                 write_clk,
  input  logic                                 rstn,
  input  logic                                 load_start_i,
  input  logic [ADDR_BITWIDTH:0]               load_page_num_i,
  input  logic                                 abort_i,
  input  logic [QUAN_SIZE-1:0]                 word_i,
  input  logic                                 word_valid_i,
  output logic                                 word_ready_o,
  output logic [QUAN_SIZE*BANK_INTERLEAVE-1:0] write_data_o,
  output logic [ADDR_BITWIDTH-1:0]             write_addr_o,
  output logic                                 we_o,
  output logic                                 busy_o,
  output logic                                 done_o
);

  localparam int DW = QUAN_SIZE * BANK_INTERLEAVE;
  localparam int CW = ADDR_BITWIDTH + 1;
  localparam int KW =
    (BANK_INTERLEAVE > 1) ? $clog2(BANK_INTERLEAVE) : 1;
  localparam logic [CW-1:0] PN     = CW'(PAGE_NUM);
  localparam logic [KW-1:0] LAST_K = KW'(BANK_INTERLEAVE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [CW-1:0]            page_cnt_q;
  logic [CW-1:0]            cnt_sel;
  logic [ADDR_BITWIDTH-1:0] page_ptr_q;
  logic [ADDR_BITWIDTH-1:0] waddr_q;
  logic [KW-1:0]            word_cnt_q;
  logic [DW-1:0]            page_buf_q;
  logic [DW-1:0]            page_nxt;
  logic [DW-1:0]            wdata_q;
  logic                     accept;
  logic                     last_word;
  logic                     last_page;

  // Zero or an out-of-range request means a full-memory load.
  always_comb begin
    cnt_sel = load_page_num_i;
    if (load_page_num_i == '0 || load_page_num_i > PN)
      cnt_sel = PN;
  end

  assign accept    = (state_q == S_FILL) && word_valid_i && !abort_i;
  assign last_word = (word_cnt_q == LAST_K);
  assign last_page = ({1'b0, page_ptr_q} + CW'(1)) >= page_cnt_q;

  // First word of a page lands in the most-significant slot.
  always_comb begin
    page_nxt = page_buf_q;
    for (int k = 0; k < BANK_INTERLEAVE; k++) begin
      if (word_cnt_q == k[KW-1:0])
        page_nxt[(BANK_INTERLEAVE-1-k)*QUAN_SIZE +: QUAN_SIZE] = word_i;
    end
  end

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    word_ready_o = 1'b0;
    we_o         = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load_start_i) state_d = S_FILL;
      end
      S_FILL: begin
        word_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (abort_i)                  state_d = S_IDLE;
        else if (accept && last_word) state_d = S_WRITE;
      end
      S_WRITE: begin
        we_o   = 1'b1;
        busy_o = 1'b1;
        if (abort_i)        state_d = S_IDLE;
        else if (last_page) state_d = S_DONE;
        else                state_d = S_FILL;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      page_cnt_q <= '0;
      page_ptr_q <= '0;
      word_cnt_q <= '0;
      page_buf_q <= '0;
      wdata_q    <= '0;
      waddr_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (load_start_i) begin
            page_cnt_q <= cnt_sel;
            page_ptr_q <= '0;
            word_cnt_q <= '0;
          end
        end
        S_FILL: begin
          if (accept) begin
            page_buf_q <= page_nxt;
            if (last_word) begin
              word_cnt_q <= '0;
              wdata_q    <= page_nxt;
              waddr_q    <= page_ptr_q;
            end else begin
              word_cnt_q <= word_cnt_q + KW'(1);
            end
          end
        end
        S_WRITE: begin
          if (!abort_i && !last_page) begin
            page_ptr_q <= page_ptr_q + ADDR_BITWIDTH'(1);
            word_cnt_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign write_data_o = wdata_q;
  assign write_addr_o = waddr_q;

endmodule

// File: tb/tb_lut_page_loader.sv
// Scoreboard bench for lut_page_loader.
// Expected page writes are queued as words are driven.
module tb_lut_page_loader;

  logic       write_clk = 1'b0;
  logic       rstn;
  logic       load_start_i;
  logic [4:0] load_page_num_i;
  logic       abort_i;
  logic [2:0] word_i;
  logic       word_valid_i;
  logic       word_ready_o;
  logic [5:0] write_data_o;
  logic [3:0] write_addr_o;
  logic       we_o;
  logic       busy_o;
  logic       done_o;

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;
  int e0    = 0;
  int we_n  = 0;
  int done_n = 0;
  int last_we_cyc = 0;
  int done_cyc = 0;
  logic [9:0] exp_q[$];

  lut_page_loader #(
    .QUAN_SIZE(3),
    .PAGE_NUM(16),
    .BANK_INTERLEAVE(2),
    .ADDR_BITWIDTH(4)
  ) dut (
    .write_clk(write_clk),
    .rstn(rstn),
    .load_start_i(load_start_i),
    .load_page_num_i(load_page_num_i),
    .abort_i(abort_i),
    .word_i(word_i),
    .word_valid_i(word_valid_i),
    .word_ready_o(word_ready_o),
    .write_data_o(write_data_o),
    .write_addr_o(write_addr_o),
    .we_o(we_o),
    .busy_o(busy_o),
    .done_o(done_o)
  );

  always #5 write_clk = ~write_clk;

  always @(posedge write_clk) ecnt <= ecnt + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  always @(negedge write_clk) begin
    logic [9:0] e;
    if (we_o) begin
      we_n++;
      last_we_cyc = ecnt - e0 + 1;
      if (exp_q.size() == 0) begin
        check("we_extra", 32'(write_addr_o), 32'hdead);
      end else begin
        e = exp_q.pop_front();
        check("waddr", 32'(write_addr_o), 32'(e[9:6]));
        check("wdata", 32'(write_data_o), 32'(e[5:0]));
      end
    end
    if (done_o) begin
      done_n++;
      done_cyc = ecnt - e0 + 1;
      check("busy_at_done", 32'(busy_o), 0);
    end
  end

  task automatic tick();
    @(posedge write_clk);
    #2;
  endtask

  task automatic start_load(input logic [4:0] n);
    load_start_i    = 1'b1;
    load_page_num_i = n;
    tick();
    load_start_i = 1'b0;
    e0 = ecnt;
  endtask

  task automatic send_word(input logic [2:0] w);
    bit ok = 0;
    word_valid_i = 1'b1;
    word_i       = w;
    for (int i = 0; i < 50; i++) begin
      if (word_ready_o) begin
        tick();
        ok = 1;
        break;
      end
      tick();
    end
    word_valid_i = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic send_page(input logic [2:0] a, input logic [2:0] b,
                           input int addr, input bit gap,
                           input bit push);
    if (push) exp_q.push_back({4'(addr), a, b});
    send_word(a);
    if (gap) tick();
    send_word(b);
    if (gap) tick();
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 200; i++) begin
      if (done_n > d0) break;
      tick();
    end
    if (done_n <= d0) check("done_timeout", 0, 1);
  endtask

  initial begin
    int w0, d0;
    rstn            = 1'b0;
    load_start_i    = 1'b0;
    load_page_num_i = '0;
    abort_i         = 1'b0;
    word_i          = '0;
    word_valid_i    = 1'b0;
    #1;
    check("rst_ready", 32'(word_ready_o), 0);
    check("rst_we", 32'(we_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_data", 32'(write_data_o), 0);
    check("rst_addr", 32'(write_addr_o), 0);
    #20 rstn = 1'b1;
    tick();

    // single page
    w0 = we_n; d0 = done_n;
    start_load(5'd1);
    send_page(3'b101, 3'b010, 0, 0, 1);
    wait_done(d0);
    check("sp_we_cyc", 32'(last_we_cyc), 3);
    check("sp_done_cyc", 32'(done_cyc), 4);
    check("sp_we_n", 32'(we_n - w0), 1);
    tick();

    // full load with count 0
    w0 = we_n; d0 = done_n;
    start_load(5'd0);
    for (int p = 0; p < 16; p++)
      send_page(3'((2*p) % 8), 3'((2*p+1) % 8), p, 0, 1);
    wait_done(d0);
    check("full_we_n", 32'(we_n - w0), 16);
    check("full_we_cyc", 32'(last_we_cyc), 48);
    check("full_done_cyc", 32'(done_cyc), 49);
    tick();

    // backpressure: valid toggles
    w0 = we_n; d0 = done_n;
    start_load(5'd2);
    send_page(3'd3, 3'd6, 0, 1, 1);
    send_page(3'd1, 3'd7, 1, 1, 1);
    wait_done(d0);
    check("bp_we_n", 32'(we_n - w0), 2);
    tick();

    // abort after first word of page 1
    w0 = we_n; d0 = done_n;
    start_load(5'd4);
    send_page(3'd4, 3'd2, 0, 0, 1);
    send_word(3'd5);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("ab_busy", 32'(busy_o), 0);
    for (int i = 0; i < 4; i++) tick();
    check("ab_we_n", 32'(we_n - w0), 1);
    check("ab_done_n", 32'(done_n - d0), 0);
    d0 = done_n;
    start_load(5'd1);
    check("ab_restart", 32'(busy_o), 1);
    send_page(3'd7, 3'd1, 0, 0, 1);
    wait_done(d0);
    tick();

    // start while busy is ignored
    w0 = we_n; d0 = done_n;
    start_load(5'd2);
    exp_q.push_back({4'd0, 3'd2, 3'd3});
    send_word(3'd2);
    load_start_i    = 1'b1;
    load_page_num_i = 5'd5;
    send_word(3'd3);
    load_start_i = 1'b0;
    send_page(3'd6, 3'd0, 1, 0, 1);
    wait_done(d0);
    check("sb_we_n", 32'(we_n - w0), 2);
    check("sb_done_cyc", 32'(done_cyc), 7);
    tick();

    // reset in WRITE of page 2
    w0 = we_n; d0 = done_n;
    start_load(5'd4);
    send_page(3'd1, 3'd2, 0, 0, 1);
    send_page(3'd3, 3'd4, 1, 0, 1);
    send_page(3'd5, 3'd6, 2, 0, 0);
    check("rm_in_write", 32'(we_o), 1);
    rstn = 1'b0;
    #1;
    check("rm_we", 32'(we_o), 0);
    check("rm_busy", 32'(busy_o), 0);
    check("rm_ready", 32'(word_ready_o), 0);
    check("rm_done", 32'(done_o), 0);
    check("rm_data", 32'(write_data_o), 0);
    check("rm_addr", 32'(write_addr_o), 0);
    tick();
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("rm_we_n", 32'(we_n - w0), 2);
    check("rm_done_n", 32'(done_n - d0), 0);
    check("rm_idle", 32'(busy_o), 0);

    check("sb_left", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
